// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI4-Stream round-robin packet arbiter.
// ARB_FLUSH (timeout flush) is only present when ARB_TIMEOUT_EN is defined.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1
`ifdef ARB_TIMEOUT_EN
    , ARB_FLUSH = 2'd2
`endif
  } arb_state_e;

  // Stall counter width; TIMEOUT_CYCLES must fit in this many bits.
  localparam int unsigned TIMEOUT_CNT_W = 16;

  // Index width for a value range; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin priority encoder: first request after last_i, modulo N.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    idx_o = last_i;
    any_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-input AXI4-Stream packet arbiter with registered output and skid buffer.
// Define ARB_TIMEOUT_EN to flush a stalled packet after TIMEOUT_CYCLES idle cycles.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_INPUTS       = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [N_INPUTS-1:0]            input_axis_tvalid,
  output logic [N_INPUTS-1:0]            input_axis_tready,
  input  logic [N_INPUTS-1:0]            input_axis_tlast,
  input  logic [N_INPUTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]          output_axis_tdata,
  output logic                           output_axis_tvalid,
  input  logic                           output_axis_tready,
  output logic                           output_axis_tlast,
  output logic                           output_axis_tuser,
  output logic [clog2(N_INPUTS)-1:0]     grant_index,
  output logic                           busy
);

  localparam int unsigned IDX_W = clog2(N_INPUTS);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d, pick_idx;
  logic                    pick_any, busy_q, busy_d;
  logic [N_INPUTS-1:0]     ready_q, ready_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d, out_user_q, out_user_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    skid_valid_q, skid_valid_d, skid_last_q, skid_last_d, skid_user_q, skid_user_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    accept, beat_last, beat_user;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic                    in_valid_g, in_last_g, in_user_g;
  logic [DATA_WIDTH-1:0]   in_data_g;
`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] stall_q, stall_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  axis_rr_pick #(.N(N_INPUTS), .IDX_W(IDX_W)) u_pick (
    .req_i  (input_axis_tvalid),
    .last_i (grant_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign in_valid_g = input_axis_tvalid[grant_q];
  assign in_last_g  = input_axis_tlast[grant_q];
  assign in_user_g  = input_axis_tuser[grant_q];
  assign in_data_g  = input_axis_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    ready_d      = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;
    accept       = 1'b0;
    beat_data    = in_data_g;
    beat_last    = in_last_g;
    beat_user    = in_user_g;
`ifdef ARB_TIMEOUT_EN
    stall_d      = stall_q;
`endif

    case (state_q)
      ARB_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        if (pick_any) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        accept = in_valid_g & ready_q[grant_q];
        if (accept && in_last_g) begin
          state_d = ARB_IDLE;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        if (accept) begin
          stall_d = '0;
        end else if (!in_valid_g) begin
          stall_d = stall_q + TIMEOUT_CNT_W'(1);
          if (stall_d == TIMEOUT_CNT_W'(TIMEOUT_CYCLES)) state_d = ARB_FLUSH;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      // Terminate the stalled packet with an error beat once the skid is free.
      ARB_FLUSH: begin
        if (!skid_valid_q) begin
          accept    = 1'b1;
          beat_data = '0;
          beat_last = 1'b1;
          beat_user = 1'b1;
          state_d   = ARB_IDLE;
          busy_d    = 1'b0;
          stall_d   = '0;
        end
      end
`endif
      default: state_d = ARB_IDLE;
    endcase

    // Output register and skid: skid always drains before new beats land.
    if (skid_valid_q) begin
      if (!out_valid_q || output_axis_tready) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || output_axis_tready) begin
        out_valid_d = 1'b1;
        out_data_d  = beat_data;
        out_last_d  = beat_last;
        out_user_d  = beat_user;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = beat_data;
        skid_last_d  = beat_last;
        skid_user_d  = beat_user;
      end
    end else if (out_valid_q && output_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (state_d == ARB_GRANT && !skid_valid_d) ready_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= IDX_W'(N_INPUTS - 1);
      busy_q       <= 1'b0;
      ready_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
`ifdef ARB_TIMEOUT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign input_axis_tready  = ready_q;
  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tdata  = out_data_q;
  assign output_axis_tlast  = out_last_q;
  assign output_axis_tuser  = out_user_q;
  assign grant_index        = grant_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: packet order, latency, backpressure, async reset.
// The timeout flush step runs only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready, in_last, in_user;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last, out_user;
  logic [1:0]      grant;
  logic            busy;

  axis_rr_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .grant_index        (grant),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int beat_no = 0;
  int cyc = 0;
  logic tog_mode = 1'b0;

  // Requester models: each presents base+pos until accepted; tlast every plen beats.
  int   src_base[N];
  int   src_len[N];
  int   src_plen[N];
  int   src_pos[N];
  logic src_user[N];
  logic [DW+1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int i, input int base, input int len, input int plen, input logic user);
    src_base[i] = base;
    src_len[i]  = len;
    src_plen[i] = plen;
    src_pos[i]  = 0;
    src_user[i] = user;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < int'(N); i++) arm(i, 0, 0, 1, 1'b0);
  endtask

  task automatic ex(input int data, input logic last, input logic user);
    exp_q.push_back({user, last, DW'(data)});
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < int'(N); i++) begin
      if (src_pos[i] < src_len[i]) begin
        in_valid[i]           = 1'b1;
        in_data[i*DW +: DW]   = DW'(src_base[i] + src_pos[i]);
        in_last[i]            = ((src_pos[i] % src_plen[i]) == src_plen[i] - 1);
        in_user[i]            = in_last[i] & src_user[i];
      end else begin
        in_valid[i]           = 1'b0;
        in_data[i*DW +: DW]   = '0;
        in_last[i]            = 1'b0;
        in_user[i]            = 1'b0;
      end
    end
  endtask

  // One clock: score any output transfer and advance accepted requesters.
  task automatic tick();
    logic [N-1:0]  acc;
    logic [DW+1:0] e;
    if (tog_mode) out_ready = cyc[0];
    drive_srcs();
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      chk("beat expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("beat %0d", beat_no), 32'({out_user, out_last, out_data}), 32'(e));
      end
      beat_no++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (acc[i]) src_pos[i]++;
    cyc++;
  endtask

  task automatic run(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    clear_srcs();
    drive_srcs();
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_user", 32'(out_user), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst grant", 32'(grant), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requester 0, three beats, latency and busy timing
    arm(0, 'hA1, 3, 3, 1'b0);
    ex('hA1, 1'b0, 1'b0); ex('hA2, 1'b0, 1'b0); ex('hA3, 1'b1, 1'b0);
    tick();
    chk("s1 busy after arb", 32'(busy), 32'd1);
    chk("s1 grant", 32'(grant), 32'd0);
    chk("s1 ready", 32'(in_ready), 32'h1);
    chk("s1 no out in arb", 32'(out_valid), 32'd0);
    tick();
    chk("s1 out_valid", 32'(out_valid), 32'd1);
    chk("s1 first data", 32'(out_data), 32'hA1);
    tick();
    tick();
    chk("s1 last data", 32'(out_data), 32'hA3);
    chk("s1 tlast", 32'(out_last), 32'd1);
    chk("s1 busy low", 32'(busy), 32'd0);
    chk("s1 ready low", 32'(in_ready), 32'd0);
    tick();
    chk("s1 out drained", 32'(out_valid), 32'd0);
    chk("s1 grant held", 32'(grant), 32'd0);
    chk("s1 queue", 32'(exp_q.size()), 32'd0);

    // All four requesters from reset: grant order 0,1,2,3 then wrap
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(N); i++) arm(i, i*16 + 1, 2, 2, 1'b0);
    ex('h01, 1'b0, 1'b0); ex('h02, 1'b1, 1'b0);
    ex('h11, 1'b0, 1'b0); ex('h12, 1'b1, 1'b0);
    ex('h21, 1'b0, 1'b0); ex('h22, 1'b1, 1'b0);
    ex('h31, 1'b0, 1'b0); ex('h32, 1'b1, 1'b0);
    run(60);
    chk("s2 grant end", 32'(grant), 32'd3);
    chk("s2 busy end", 32'(busy), 32'd0);
    arm(2, 'h2A, 1, 1, 1'b1);
    arm(0, 'h0A, 1, 1, 1'b0);
    ex('h0A, 1'b1, 1'b0); ex('h2A, 1'b1, 1'b1);
    run(30);
    chk("s2 wrap grant", 32'(grant), 32'd2);

    // Requester 2 streams 8 beats under alternating backpressure
    arm(2, 'h30, 8, 8, 1'b1);
    for (int b = 0; b < 7; b++) ex('h30 + b, 1'b0, 1'b0);
    ex('h37, 1'b1, 1'b1);
    tog_mode = 1'b1;
    run(80);
    tog_mode = 1'b0;
    out_ready = 1'b1;
    chk("s3 busy end", 32'(busy), 32'd0);

    // Requester 1 re-requests while 3 waits: 3 must be served between
    arm(1, 'h40, 4, 2, 1'b0);
    tick();
    chk("s4 grant first", 32'(grant), 32'd1);
    arm(3, 'h60, 2, 2, 1'b1);
    ex('h40, 1'b0, 1'b0); ex('h41, 1'b1, 1'b0);
    ex('h60, 1'b0, 1'b0); ex('h61, 1'b1, 1'b1);
    ex('h42, 1'b0, 1'b0); ex('h43, 1'b1, 1'b0);
    run(60);
    chk("s4 grant end", 32'(grant), 32'd1);

    // Asynchronous reset mid-packet
    arm(0, 'h50, 4, 4, 1'b0);
    ex('h50, 1'b0, 1'b0);
    tick();
    chk("s5 grant", 32'(grant), 32'd0);
    tick();
    tick();
    chk("s5 mid data", 32'(out_data), 32'h51);
    #3;
    rst = 1'b1;
    #1;
    chk("s5 async valid", 32'(out_valid), 32'd0);
    chk("s5 async busy", 32'(busy), 32'd0);
    chk("s5 async ready", 32'(in_ready), 32'd0);
    chk("s5 async grant", 32'(grant), 32'd3);
    chk("s5 queue", 32'(exp_q.size()), 32'd0);
    clear_srcs();
    drive_srcs();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    arm(2, 'h72, 1, 1, 1'b0);
    arm(0, 'h70, 1, 1, 1'b1);
    ex('h70, 1'b1, 1'b1); ex('h72, 1'b1, 1'b0);
    run(30);
    chk("s5 grant end", 32'(grant), 32'd2);

`ifdef ARB_TIMEOUT_EN
    // Requester 1 abandons its packet; an error beat closes it
    arm(1, 'h81, 1, 2, 1'b0);
    ex('h81, 1'b0, 1'b0);
    ex('h00, 1'b1, 1'b1);
    run(40);
    chk("s6 busy end", 32'(busy), 32'd0);
    chk("s6 grant", 32'(grant), 32'd1);
    tick();
    chk("s6 idle out", 32'(out_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
